bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD counter that counts up or down. It is the successor to the 4-bit single-digit down counter used for the game timer and score displays.
It keeps the 74161-style control set (load, two count enables, cascade output) and adds:
- DIGITS-wide BCD operation
- direction select
- selectable wrap or saturate at the terminal value
- loaded-value sanitising
- a registered terminal-reached pulse
It sits between the game-control FSM and the 7-segment display drivers.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_updown_counter.sv | 86 ++++++++
 tb/tb_bcd_updown_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and digit helpers for the up/down BCD counter.
package bcd_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 16;
  localparam int         MAX_W      = BCD_W * MAX_DIGITS;

  function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

  // True when the lowest ndigits digits of value all equal digit.
  function automatic logic all_digits_eq(input logic [MAX_W-1:0] value,
                                         input int               ndigits,
                                         input logic [3:0]       digit);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < ndigits) && (value[BCD_W*i +: BCD_W] != digit)) begin
        eq = 1'b0;
      end
    end
    return eq;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: reset, sanitised load, and an enabled
// up/down step with a chain flag toward the next digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       CP,
  input  logic       CR,
  input  logic [3:0] rst_digit,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       en_in,
  input  logic       UpDn,
  output logic [3:0] q,
  output logic       chain_out
);

  // Digit state: reset > load > step > hold
  always_ff @(posedge CP) begin
    if (CR) begin
      q <= rst_digit;
    end else if (load) begin
      q <= bcd_sat(load_digit);
    end else if (en_in) begin
      if (UpDn) begin
        q <= (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
      end else begin
        q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      end
    end else begin
      q <= q;
    end
  end

  // Digit is at the roll-over point for the current direction
  always_comb begin
    if (UpDn) begin
      chain_out = (q >= BCD_MAX);
    end else begin
      chain_out = (q == 4'd0);
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with 74161-style load/enable/cascade,
// wrap or saturate at the terminal value and a registered Done pulse.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int                    DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]   RST_VAL = {DIGITS{4'h9}},
  parameter int                    WRAP    = 1
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  Ld,
  input  logic                  CTP,
  input  logic                  CTT,
  input  logic                  UpDn,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  CO,
  output logic                  Zero,
  output logic                  Done
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] chain;
  logic              at_terminal;
  logic              step_en;
  logic              near_terminal;
  logic [3:0]        near_digit;
  logic [3:0]        term_digit;

  // Every digit's chain flag set means the whole value is at the terminal
  assign at_terminal = &chain;
  assign step_en     = CTP & CTT & (WRAP_EN | ~at_terminal);
  assign CO          = CTT & at_terminal;
  assign Zero        = all_digits_eq(MAX_W'(Q), DIGITS, 4'd0);

  // One step away from terminal: 0..01 going down, 9..98 going up
  always_comb begin
    if (UpDn) begin
      near_digit = 4'd8;
      term_digit = BCD_MAX;
    end else begin
      near_digit = 4'd1;
      term_digit = 4'd0;
    end
  end

  assign near_terminal = (Q[3:0] == near_digit) &&
                         all_digits_eq(MAX_W'(Q >> BCD_W), DIGITS - 1, term_digit);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign en[k] = step_en;
    end else begin : g_rest
      assign en[k] = en[k-1] & chain[k-1];
    end

    bcd_digit u_digit (
      .CP         (CP),
      .CR         (CR),
      .rst_digit  (RST_VAL[BCD_W*k +: BCD_W]),
      .load       (~Ld),
      .load_digit (D[BCD_W*k +: BCD_W]),
      .en_in      (en[k]),
      .UpDn       (UpDn),
      .q          (Q[BCD_W*k +: BCD_W]),
      .chain_out  (chain[k])
    );
  end

  // Done pulses for one cycle after a step lands on the terminal value
  always_ff @(posedge CP) begin
    if (CR) begin
      Done <= 1'b0;
    end else if (!Ld) begin
      Done <= 1'b0;
    end else if (step_en && near_terminal) begin
      Done <= 1'b1;
    end else begin
      Done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: wrap and saturate instances plus a two-stage
// single-digit cascade, all checked against an integer reference model.
module tb_bcd_updown_counter;

  logic       CP = 1'b0;
  logic       CR, Ld, CTP, CTT, UpDn;
  logic [7:0] D;

  logic [7:0] q_w, q_s;
  logic       co_w, zero_w, done_w, co_s, zero_s, done_s;
  logic [3:0] q_lo, q_hi;
  logic       co_lo, co_hi, zero_lo, zero_hi, done_lo, done_hi;

  int tests = 0;
  int fails = 0;
  int v_w, v_s;
  bit dn_w, dn_s;

  always #5 CP = ~CP;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut_w (
    .CP(CP), .CR(CR), .Ld(Ld), .CTP(CTP), .CTT(CTT), .UpDn(UpDn), .D(D),
    .Q(q_w), .CO(co_w), .Zero(zero_w), .Done(done_w));

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) dut_s (
    .CP(CP), .CR(CR), .Ld(Ld), .CTP(CTP), .CTT(CTT), .UpDn(UpDn), .D(D),
    .Q(q_s), .CO(co_s), .Zero(zero_s), .Done(done_s));

  bcd_updown_counter #(.DIGITS(1), .RST_VAL(4'h9), .WRAP(1)) dut_lo (
    .CP(CP), .CR(CR), .Ld(Ld), .CTP(CTP), .CTT(CTT), .UpDn(UpDn), .D(D[3:0]),
    .Q(q_lo), .CO(co_lo), .Zero(zero_lo), .Done(done_lo));

  bcd_updown_counter #(.DIGITS(1), .RST_VAL(4'h9), .WRAP(1)) dut_hi (
    .CP(CP), .CR(CR), .Ld(Ld), .CTP(CTP), .CTT(co_lo), .UpDn(UpDn), .D(D[7:4]),
    .Q(q_hi), .CO(co_hi), .Zero(zero_hi), .Done(done_hi));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens, ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  function automatic int sanitise(input logic [7:0] d);
    int tens, ones;
    tens = (d[7:4] > 4'd9) ? 9 : int'(d[7:4]);
    ones = (d[3:0] > 4'd9) ? 9 : int'(d[3:0]);
    return tens * 10 + ones;
  endfunction

  function automatic bit is_term(input int v, input bit up);
    return up ? (v == 99) : (v == 0);
  endfunction

  // Integer model of one rising edge for a 00..99 counter
  task automatic model_edge(inout int v, inout bit dn, input bit wrap);
    if (CR) begin
      v = 99; dn = 1'b0;
    end else if (!Ld) begin
      v = sanitise(D); dn = 1'b0;
    end else if (CTP && CTT) begin
      if (is_term(v, UpDn)) begin
        if (wrap) v = UpDn ? 0 : 99;
        dn = 1'b0;
      end else begin
        v = UpDn ? v + 1 : v - 1;
        dn = is_term(v, UpDn);
      end
    end else begin
      dn = 1'b0;
    end
  endtask

  task automatic drive(input bit cr, input bit ld, input bit ctp, input bit ctt,
                       input bit up, input logic [7:0] d);
    CR = cr; Ld = ld; CTP = ctp; CTT = ctt; UpDn = up; D = d;
    #1;
    check("co_wrap", co_w, ctt && is_term(v_w, up));
    check("co_sat",  co_s, ctt && is_term(v_s, up));
    @(posedge CP);
    model_edge(v_w, dn_w, 1'b1);
    model_edge(v_s, dn_s, 1'b0);
    @(negedge CP);
    check("q_wrap",    q_w,    to_bcd(v_w));
    check("done_wrap", done_w, dn_w);
    check("zero_wrap", zero_w, v_w == 0);
    check("q_sat",     q_s,    to_bcd(v_s));
    check("done_sat",  done_s, dn_s);
    check("zero_sat",  zero_s, v_s == 0);
    check("q_cascade", {q_hi, q_lo}, to_bcd(v_w));
  endtask

  initial begin
    bit up_r;
    CR = 1'b1; Ld = 1'b1; CTP = 1'b0; CTT = 1'b0; UpDn = 1'b0; D = 8'h00;
    @(posedge CP);
    @(negedge CP);
    v_w = 99; v_s = 99; dn_w = 1'b0; dn_s = 1'b0;
    check("rst_q", q_w, 8'h99);
    check("rst_done", done_w, 1'b0);
    check("rst_cascade", {q_hi, q_lo}, 8'h99);

    // Full down count and wrap / saturate at zero
    repeat (99) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("down_end_q", q_w, 8'h00);
    check("down_end_done", done_w, 1'b1);
    check("down_end_co", co_w, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("wrap_q", q_w, 8'h99);
    check("wrap_done", done_w, 1'b0);
    check("sat_q", q_s, 8'h00);
    check("sat_done", done_s, 1'b0);

    // Sanitised loads
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA7);
    check("load_a7", q_w, 8'h97);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3F);
    check("load_3f", q_w, 8'h39);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("load_00_zero", zero_w, 1'b1);
    check("load_00_done", done_w, 1'b0);

    // Up count with carry and terminal pulse
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    check("up_carry", q_w, 8'h10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    check("up_term_q", q_w, 8'h99);
    check("up_term_done", done_w, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    check("ctt_low_hold", q_w, 8'h99);

    // Priority: reset over load, load over count, reset mid-count
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12);
    check("rst_over_load", q_w, 8'h99);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h45);
    check("load_over_count", q_w, 8'h45);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("rst_mid_count", q_w, 8'h99);

    // Cascade from 21 downward, compared edge for edge via the model
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("cascade_20", {q_hi, q_lo}, 8'h20);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("cascade_19", {q_hi, q_lo}, 8'h19);
    repeat (25) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

    // Randomised traffic with occasional direction changes
    up_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) up_r = ~up_r;
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 15) != 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) != 0,
            up_r,
            8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
